// File: rtl/reg_bus_arbiter.sv
// ============================================================================
// Module  : reg_bus_arbiter
// Brief   : Round-robin arbiter sharing one control-register bus among masters,
//           one single-beat write or read per grant (IDLE -> ISSUE -> RESP).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 33,
  parameter int DATA_W      = 33,
  parameter int RDATA_W     = 21
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        req_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] req_wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        ack,
  output logic [RDATA_W-1:0]            rsp_rdata,
  output logic                          busy,
  output logic [ADDR_W-1:0]             reg_address,
  output logic                          reg_write_enable,
  output logic [DATA_W-1:0]             reg_write_data,
  output logic                          reg_read_enable,
  input  logic [RDATA_W-1:0]            reg_read_data
);

  localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_launch;

  logic [c_IDX_W-1:0]       r_ptr;
  logic [c_IDX_W-1:0]       r_winner;
  logic                     r_write;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_wdata;
  logic [RDATA_W-1:0]       r_rdata;

  logic [NUM_MASTERS-1:0]   w_rot;
  logic                     w_found;
  logic [c_IDX_W-1:0]       w_winner;
  logic                     w_sel_write;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_wdata;
  logic [NUM_MASTERS-1:0]   w_onehot;

  function automatic int f_wrap(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return s;
  endfunction

  // Rotate requests so bit 0 is the master at ptr; first set bit wins.
  always_comb begin
    w_rot    = NUM_MASTERS'({req, req} >> r_ptr);
    w_found  = 1'b0;
    w_winner = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found  = 1'b1;
        w_winner = c_IDX_W'(f_wrap(int'(r_ptr), j));
      end
    end
  end

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (c_IDX_W'(i) == w_winner) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_launch     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_winner <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_launch) begin
        r_winner <= w_winner;
        r_write  <= w_sel_write;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
      end
      if (r_state == S_ISSUE && !r_write) r_rdata <= reg_read_data;
      if (r_state == S_RESP) r_ptr <= c_IDX_W'(f_wrap(int'(r_winner), 1));
    end
  end

  // Outputs decode from the state register, so async reset clears them at once.
  assign w_onehot         = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_winner;
  assign gnt              = (r_state != S_IDLE) ? w_onehot : '0;
  assign ack              = (r_state == S_RESP) ? w_onehot : '0;
  assign busy             = (r_state != S_IDLE);
  assign reg_write_enable = (r_state == S_ISSUE) && r_write;
  assign reg_read_enable  = (r_state == S_ISSUE) && !r_write;
  assign reg_address      = r_addr;
  assign reg_write_data   = r_wdata;
  assign rsp_rdata        = r_rdata;

endmodule

`default_nettype wire
